multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Multi-cycle sequencer for the RV32I datapath (PC, instr/data memory, register file, ALU, ALU control).
//  Replaces the single-cycle control_unit and free-running PC increment.
//  Steps each instruction through FETCH/DECODE/EXEC/MEM/WB, issuing per-cycle enables and mux selects.
//  Handshakes with a variable-latency memory port shared by instruction fetch and data access.
// PARAMETERS
//  MEM_TIMEOUT  16  cycles mem_req may stay unanswered before bus error; 0 disables the watchdog
//  CNT_W        5   width of the watchdog counter; requires MEM_TIMEOUT < 2**CNT_W
// PORTS
//  clk            in   1  single clock, rising edge
//  reset          in   1  asynchronous, active-low reset
//  opcode         in   7  instr[6:0] from the instruction register (decoder output)
//  branch_cond    in   1  datapath comparator: branch condition for current func3 is true
//  mem_ready      in   1  memory completes the access this cycle (read data valid)
//  pc_we          out  1  load PC
//  pc_src         out  1  PC source: 0 = ALU result, 1 = ALUOut register
//  ir_we          out  1  load instruction register and old-PC register
//  iord           out  1  memory address: 0 = PC, 1 = ALUOut
//  mem_req        out  1  memory access request, held until mem_ready
//  mem_we         out  1  write qualifier for mem_req
//  reg_we         out  1  register-file write enable
//  alu_src_a      out  2  00 PC, 01 old PC, 10 rs1, 11 zero
//  alu_src_b      out  2  00 rs2, 01 imm, 10 const 4
//  alu_op         out  2  00 add, 01 subtract/compare, 10 func3/func7 decoded
//  result_src     out  2  00 ALUOut, 01 memory read data, 10 ALU result (direct)
//  retire         out  1  one-cycle pulse, instruction completed
//  illegal_instr  out  1  sticky, unsupported opcode decoded
//  bus_err        out  1  sticky, memory watchdog expired
//  busy           out  1  high in every state except TRAP
// BEHAVIOUR
//  - Reset (reset=0, async): state=FETCH, watchdog=0, sticky flags=0.
//    All strobes 0 while reset is low, including mem_req.
//  - First edge after reset release: FETCH drives mem_req=1, iord=0.
//  - Outputs are combinational from state (plus mem_ready/branch_cond where noted); state is the only FSM register.
//  - Handshake: mem_req and mem_we stay stable until a cycle with mem_ready=1.
//    That cycle completes the access. mem_ready while mem_req=0 is ignored.
//  - FETCH: mem_req. On mem_ready: ir_we=1, pc_we=1, pc_src=0, src_a=00, src_b=10, alu_op=00; go DECODE.
//  - DECODE: src_a=01, src_b=01, alu_op=00 (ALUOut <= oldPC+imm). Next state by opcode:
//      0110011 -> EXEC_R; 0010011 -> EXEC_I; 0000011 and 0100011 -> MEMADR; 1100011 -> BRANCH;
//      1101111 -> JUMP; 1100111 -> JALR_ADR; 0110111 -> LUI; any other -> TRAP, illegal_instr=1.
//  - EXEC_R:   src_a=10, src_b=00, alu_op=10 -> ALUWB
//  - EXEC_I:   src_a=10, src_b=01, alu_op=10 -> ALUWB
//  - LUI:      src_a=11, src_b=01, alu_op=00 -> ALUWB
//  - ALUWB:    reg_we=1, result_src=00, retire=1 -> FETCH
//  - MEMADR:   src_a=10, src_b=01, alu_op=00 -> MEMRD if opcode=0000011, else MEMWR
//  - MEMRD:    mem_req, iord=1; on mem_ready -> MEMWB
//  - MEMWB:    reg_we=1, result_src=01, retire=1 -> FETCH
//  - MEMWR:    mem_req, mem_we, iord=1; on mem_ready: retire=1 -> FETCH
//  - BRANCH:   src_a=10, src_b=00, alu_op=01; pc_we=branch_cond, pc_src=1; retire=1 -> FETCH
//  - JALR_ADR: src_a=10, src_b=01, alu_op=00 -> JUMP
//  - JUMP:     src_a=01, src_b=10, alu_op=00, result_src=10, reg_we=1, pc_we=1, pc_src=1, retire=1 -> FETCH
//  - TRAP:     all strobes 0, busy=0; absorbing until reset.
//  - Watchdog: counts cycles with mem_req=1 and mem_ready=0; clears on every completed access and on state change.
//    When MEM_TIMEOUT!=0 and count reaches MEM_TIMEOUT: go TRAP, bus_err=1, mem_req drops the next cycle.
//    mem_ready arriving in the expiry cycle wins: access completes, no error.
//  - At most one of reg_we/mem_we asserted in any cycle; pc_we and ir_we never asserted in TRAP.
//  - Reset asserted mid-access drops mem_req asynchronously; no partial commit is guaranteed to memory.
// STRUCTURE
//  - riscv_ctrl_pkg: state_t enum; OPC_* opcode constants; ALU_A_*, ALU_B_*, ALUOP_*, RES_* encodings.
//    Shared with alu_control and the datapath muxes.
//  - Sub-module mem_wdog (counter + expiry compare) instantiated once; FSM and output decode stay in this module.
// TESTING
//  - Reset: hold reset=0 with mem_ready=1 -> all outputs 0.
//    Release -> mem_req=1, iord=0 on the first cycle.
//  - ADD (0110011), mem_ready on 1st request -> FETCH,DECODE,EXEC_R,ALUWB: reg_we in cycle 4, retire once.
//    4 cycles total.
//  - LW with fetch ready delay 3 and data ready delay 2 -> mem_req continuous during waits.
//    result_src=01 with reg_we; retire after 10 cycles.
//  - BEQ: branch_cond=0 -> pc_we=0 in BRANCH. branch_cond=1 -> pc_we=1, pc_src=1. Both retire.
//  - Opcode 7'h7F -> TRAP after DECODE: illegal_instr=1, busy=0, no further mem_req for 20 cycles.
//  - MEM_TIMEOUT=4, mem_ready stuck 0 in FETCH -> bus_err=1 after 4 waiting cycles.
//    Repeat with mem_ready arriving on the 4th cycle -> no error.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared control encodings for the multi-cycle RV32I datapath: sequencer
// states, major opcodes and the mux/ALU select values driven to the datapath.
package riscv_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC_R,
      S_EXEC_I,
      S_LUI,
      S_ALUWB,
      S_MEMADR,
      S_MEMRD,
      S_MEMWB,
      S_MEMWR,
      S_BRANCH,
      S_JALR_ADR,
      S_JUMP,
      S_TRAP
   } state_t;

   localparam logic [6:0] OPC_R      = 7'b0110011;
   localparam logic [6:0] OPC_I      = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;

   localparam logic [1:0] ALU_A_PC    = 2'b00;
   localparam logic [1:0] ALU_A_OLDPC = 2'b01;
   localparam logic [1:0] ALU_A_RS1   = 2'b10;
   localparam logic [1:0] ALU_A_ZERO  = 2'b11;

   localparam logic [1:0] ALU_B_RS2  = 2'b00;
   localparam logic [1:0] ALU_B_IMM  = 2'b01;
   localparam logic [1:0] ALU_B_FOUR = 2'b10;

   localparam logic [1:0] ALUOP_ADD  = 2'b00;
   localparam logic [1:0] ALUOP_SUB  = 2'b01;
   localparam logic [1:0] ALUOP_FUNC = 2'b10;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_MEM    = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

   // Successor of DECODE for a given opcode; anything unsupported traps.
   function automatic state_t decode_next(input logic [6:0] opc);
      state_t nxt;
      case (opc)
         OPC_R:      nxt = S_EXEC_R;
         OPC_I:      nxt = S_EXEC_I;
         OPC_LOAD:   nxt = S_MEMADR;
         OPC_STORE:  nxt = S_MEMADR;
         OPC_BRANCH: nxt = S_BRANCH;
         OPC_JAL:    nxt = S_JUMP;
         OPC_JALR:   nxt = S_JALR_ADR;
         OPC_LUI:    nxt = S_LUI;
         default:    nxt = S_TRAP;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/mem_wdog.sv
// Memory handshake watchdog: counts cycles a request waits unanswered and
// flags the cycle in which the wait limit is reached. A ready response in
// that same cycle suppresses the expiry, so a late-but-in-time access wins.
module mem_wdog #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 5
) (
   input  logic clk,
   input  logic reset,
   input  logic req,
   input  logic ready,
   input  logic state_chg,
   output logic expire
);

   logic [CNT_W-1:0] count;

   // Wait counter: cleared by a completed access or any sequencer state change.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (state_chg || (req && ready)) begin
         count <= '0;
      end else if (req && !ready && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

   generate
      if (MEM_TIMEOUT == 0) begin : g_off
         assign expire = 1'b0;
      end else begin : g_on
         localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_TIMEOUT - 1);
         // This waiting cycle is the MEM_TIMEOUT-th one.
         assign expire = req && !ready && (count == LAST);
      end
   endgenerate

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer. Walks each instruction through
// FETCH/DECODE/EXEC/MEM/WB and decodes per-state enables and mux selects.
// Outputs are combinational from the state; the sticky error flags and a
// one-bit "started" marker are the only other registers. The marker keeps
// every strobe low until the first clock edge after reset release.
module multicycle_ctrl
   import riscv_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] opcode,
   input  logic       branch_cond,
   input  logic       mem_ready,
   output logic       pc_we,
   output logic       pc_src,
   output logic       ir_we,
   output logic       iord,
   output logic       mem_req,
   output logic       mem_we,
   output logic       reg_we,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] result_src,
   output logic       retire,
   output logic       illegal_instr,
   output logic       bus_err,
   output logic       busy
);

   state_t state;
   state_t state_next;
   logic   started;
   logic   expire;
   logic   done;

   assign done = mem_req && mem_ready;

   mem_wdog #(
      .MEM_TIMEOUT(MEM_TIMEOUT),
      .CNT_W      (CNT_W)
   ) u_wdog (
      .clk      (clk),
      .reset    (reset),
      .req      (mem_req),
      .ready    (mem_ready),
      .state_chg(state_next != state),
      .expire   (expire)
   );

   // Next-state selection; a watchdog expiry overrides everything.
   always_comb begin
      state_next = state;
      case (state)
         S_FETCH:    if (done) state_next = S_DECODE;
         S_DECODE:   state_next = decode_next(opcode);
         S_EXEC_R:   state_next = S_ALUWB;
         S_EXEC_I:   state_next = S_ALUWB;
         S_LUI:      state_next = S_ALUWB;
         S_ALUWB:    state_next = S_FETCH;
         S_MEMADR:   state_next = (opcode == OPC_LOAD) ? S_MEMRD : S_MEMWR;
         S_MEMRD:    if (done) state_next = S_MEMWB;
         S_MEMWB:    state_next = S_FETCH;
         S_MEMWR:    if (done) state_next = S_FETCH;
         S_BRANCH:   state_next = S_FETCH;
         S_JALR_ADR: state_next = S_JUMP;
         S_JUMP:     state_next = S_FETCH;
         S_TRAP:     state_next = S_TRAP;
         default:    state_next = S_TRAP;
      endcase
      if (expire) state_next = S_TRAP;
   end

   // State register plus sticky error flags.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= S_FETCH;
         started       <= 1'b0;
         illegal_instr <= 1'b0;
         bus_err       <= 1'b0;
      end else begin
         started <= 1'b1;
         state   <= state_next;
         if ((state == S_DECODE) && (state_next == S_TRAP)) illegal_instr <= 1'b1;
         if (expire) bus_err <= 1'b1;
      end
   end

   // Per-state strobes and datapath selects.
   always_comb begin
      pc_we      = 1'b0;
      pc_src     = 1'b0;
      ir_we      = 1'b0;
      iord       = 1'b0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      reg_we     = 1'b0;
      alu_src_a  = ALU_A_PC;
      alu_src_b  = ALU_B_RS2;
      alu_op     = ALUOP_ADD;
      result_src = RES_ALUOUT;
      retire     = 1'b0;
      busy       = started && (state != S_TRAP);
      case (state)
         S_FETCH: begin
            if (started) begin
               mem_req   = 1'b1;
               iord      = 1'b0;
               alu_src_a = ALU_A_PC;
               alu_src_b = ALU_B_FOUR;
               alu_op    = ALUOP_ADD;
               ir_we     = mem_ready;
               pc_we     = mem_ready;
               pc_src    = 1'b0;
            end
         end
         S_DECODE: begin
            alu_src_a = ALU_A_OLDPC;
            alu_src_b = ALU_B_IMM;
            alu_op    = ALUOP_ADD;
         end
         S_EXEC_R: begin
            alu_src_a = ALU_A_RS1;
            alu_src_b = ALU_B_RS2;
            alu_op    = ALUOP_FUNC;
         end
         S_EXEC_I: begin
            alu_src_a = ALU_A_RS1;
            alu_src_b = ALU_B_IMM;
            alu_op    = ALUOP_FUNC;
         end
         S_LUI: begin
            alu_src_a = ALU_A_ZERO;
            alu_src_b = ALU_B_IMM;
            alu_op    = ALUOP_ADD;
         end
         S_ALUWB: begin
            reg_we     = 1'b1;
            result_src = RES_ALUOUT;
            retire     = 1'b1;
         end
         S_MEMADR, S_JALR_ADR: begin
            alu_src_a = ALU_A_RS1;
            alu_src_b = ALU_B_IMM;
            alu_op    = ALUOP_ADD;
         end
         S_MEMRD: begin
            mem_req = 1'b1;
            iord    = 1'b1;
         end
         S_MEMWB: begin
            reg_we     = 1'b1;
            result_src = RES_MEM;
            retire     = 1'b1;
         end
         S_MEMWR: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            iord    = 1'b1;
            retire  = mem_ready;
         end
         S_BRANCH: begin
            alu_src_a = ALU_A_RS1;
            alu_src_b = ALU_B_RS2;
            alu_op    = ALUOP_SUB;
            pc_we     = branch_cond;
            pc_src    = 1'b1;
            retire    = 1'b1;
         end
         S_JUMP: begin
            alu_src_a  = ALU_A_OLDPC;
            alu_src_b  = ALU_B_FOUR;
            alu_op     = ALUOP_ADD;
            result_src = RES_ALU;
            reg_we     = 1'b1;
            pc_we      = 1'b1;
            pc_src     = 1'b1;
            retire     = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl. Each instruction is described at the level of
// "what must happen per cycle" and expanded into a per-cycle schedule of
// stimulus plus expected outputs (with a mask of meaningful fields).
module tb_multicycle_ctrl;

   localparam int TMO = 4;

   logic       clk;
   logic       reset;
   logic [6:0] opcode;
   logic       branch_cond;
   logic       mem_ready;
   logic       pc_we, pc_src, ir_we, iord, mem_req, mem_we, reg_we;
   logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
   logic       retire, illegal_instr, bus_err, busy;

   multicycle_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(5)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .branch_cond(branch_cond),
      .mem_ready(mem_ready), .pc_we(pc_we), .pc_src(pc_src), .ir_we(ir_we),
      .iord(iord), .mem_req(mem_req), .mem_we(mem_we), .reg_we(reg_we),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .result_src(result_src), .retire(retire), .illegal_instr(illegal_instr),
      .bus_err(bus_err), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic       pc_we, pc_src, ir_we, iord, mem_req, mem_we, reg_we;
      logic [1:0] a, b, op, res;
      logic       retire, illegal, bus_err, busy;
   } ctl_t;

   typedef struct {
      logic       rdy;
      logic       bc;
      logic [6:0] opc;
      ctl_t       e;
      ctl_t       m;
   } step_t;

   step_t sched[$];
   ctl_t  act, ce, cm, cur_e, cur_m;
   bit    m_ill, m_berr, m_trap;
   bit    chk_en;
   int    cyc;
   int    n_checks, n_fail;
   int    obs_retire, obs_retire_cyc, obs_regwe_cyc, obs_memreq, obs_pcwe;

   assign act = {pc_we, pc_src, ir_we, iord, mem_req, mem_we, reg_we,
                 alu_src_a, alu_src_b, alu_op, result_src,
                 retire, illegal_instr, bus_err, busy};

   // ---------------- behavioural model: instruction -> cycle schedule
   task automatic beg();
      ce = '0;
      ce.illegal = m_ill;
      ce.bus_err = m_berr;
      ce.busy    = !m_trap;
      cm = '0;
      cm.pc_we = 1; cm.ir_we = 1; cm.mem_req = 1; cm.mem_we = 1; cm.reg_we = 1;
      cm.retire = 1; cm.illegal = 1; cm.bus_err = 1; cm.busy = 1;
   endtask

   task automatic sel(input logic [1:0] a, input logic [1:0] b, input logic [1:0] op);
      ce.a = a; ce.b = b; ce.op = op;
      cm.a = 2'b11; cm.b = 2'b11; cm.op = 2'b11;
   endtask

   task automatic fin(input logic rdy, input logic bc, input logic [6:0] opc);
      step_t s;
      s.rdy = rdy; s.bc = bc; s.opc = opc; s.e = ce; s.m = cm;
      sched.push_back(s);
   endtask

   // Cycles spent waiting for memory; ok=0 means the watchdog fired.
   task automatic mem_wait(input int dly, input logic [6:0] opc, input logic we,
                           input logic io, output bit ok);
      int n;
      n = (dly >= TMO) ? TMO : dly;
      for (int k = 0; k < n; k++) begin
         beg(); ce.mem_req = 1; ce.mem_we = we; ce.iord = io; cm.iord = 1;
         fin(1'b0, 1'b0, opc);
      end
      ok = (dly < TMO);
      if (!ok) begin m_trap = 1; m_berr = 1; end
   endtask

   task automatic add_instr(input logic [6:0] opc, input int fdly, input int ddly, input logic bc);
      bit ok;
      mem_wait(fdly, opc, 1'b0, 1'b0, ok);
      if (!ok) return;
      // fetch completes: load IR and PC <= PC+4
      beg(); ce.mem_req = 1; cm.iord = 1; ce.ir_we = 1; ce.pc_we = 1; cm.pc_src = 1;
      sel(2'b00, 2'b10, 2'b00); fin(1'b1, 1'b0, opc);
      // decode: ALUOut <= oldPC + imm (mem_ready high here must be ignored)
      beg(); sel(2'b01, 2'b01, 2'b00); fin(1'b1, 1'b0, opc);
      case (opc)
         7'b0110011, 7'b0010011, 7'b0110111: begin
            beg();
            if (opc == 7'b0110011)      sel(2'b10, 2'b00, 2'b10);
            else if (opc == 7'b0010011) sel(2'b10, 2'b01, 2'b10);
            else                        sel(2'b11, 2'b01, 2'b00);
            fin(1'b1, 1'b0, opc);
            beg(); ce.reg_we = 1; ce.retire = 1; cm.res = 2'b11; ce.res = 2'b00;
            fin(1'b1, 1'b0, opc);
         end
         7'b0000011, 7'b0100011: begin
            beg(); sel(2'b10, 2'b01, 2'b00); fin(1'b1, 1'b0, opc);
            mem_wait(ddly, opc, (opc == 7'b0100011), 1'b1, ok);
            if (!ok) return;
            beg(); ce.mem_req = 1; ce.iord = 1; cm.iord = 1;
            if (opc == 7'b0100011) begin ce.mem_we = 1; ce.retire = 1; end
            fin(1'b1, 1'b0, opc);
            if (opc == 7'b0000011) begin
               beg(); ce.reg_we = 1; ce.retire = 1; ce.res = 2'b01; cm.res = 2'b11;
               fin(1'b0, 1'b0, opc);
            end
         end
         7'b1100011: begin
            beg(); sel(2'b10, 2'b00, 2'b01); ce.pc_we = bc; ce.retire = 1;
            if (bc) begin ce.pc_src = 1; cm.pc_src = 1; end
            fin(1'b1, bc, opc);
         end
         7'b1101111, 7'b1100111: begin
            if (opc == 7'b1100111) begin
               beg(); sel(2'b10, 2'b01, 2'b00); fin(1'b1, 1'b0, opc);
            end
            beg(); sel(2'b01, 2'b10, 2'b00); ce.res = 2'b10; cm.res = 2'b11;
            ce.reg_we = 1; ce.pc_we = 1; ce.pc_src = 1; cm.pc_src = 1; ce.retire = 1;
            fin(1'b1, 1'b0, opc);
         end
         default: begin
            m_trap = 1; m_ill = 1;
         end
      endcase
   endtask

   task automatic add_trap(input int n);
      for (int k = 0; k < n; k++) begin
         beg(); fin(1'b1, 1'b1, 7'h7F);
      end
   endtask

   // ---------------- driver
   task automatic run_phase();
      chk_en = 1;
      foreach (sched[i]) begin
         mem_ready   = sched[i].rdy;
         branch_cond = sched[i].bc;
         opcode      = sched[i].opc;
         cur_e       = sched[i].e;
         cur_m       = sched[i].m;
         cyc         = i + 1;
         @(posedge clk);
         #1;
      end
      chk_en = 0;
      sched.delete();
   endtask

   task automatic check(input string nm, input int got, input int req);
      n_checks++;
      if (got != req) begin
         n_fail++;
         $display("FAIL %s: got %0d required %0d", nm, got, req);
      end
   endtask

   // ---------------- compare process: every scheduled cycle
   always @(negedge clk) begin
      if (chk_en) begin
         n_checks++;
         if (((act ^ cur_e) & cur_m) !== '0) begin
            n_fail++;
            $display("FAIL ctl_cycle_%0d: got %b required %b mask %b", cyc, act, cur_e, cur_m);
         end else begin
            $display("cycle %0d ok outputs %b", cyc, act);
         end
         if (retire === 1'b1) begin obs_retire++; obs_retire_cyc = cyc; end
         if (reg_we === 1'b1) obs_regwe_cyc = cyc;
         if (mem_req === 1'b1) obs_memreq++;
         if (pc_we === 1'b1) obs_pcwe++;
      end
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: got running required finished");
      $fatal(1, "timeout");
   end

   initial begin
      int r0, q0, p0;
      reset = 0; mem_ready = 1; opcode = 7'h33; branch_cond = 1;
      chk_en = 0; cyc = 0; n_checks = 0; n_fail = 0;
      m_ill = 0; m_berr = 0; m_trap = 0;
      repeat (3) @(posedge clk);
      #1 check("reset_outputs_zero", int'(act), 0);
      @(negedge clk) reset = 1;
      #1 check("pre_edge_mem_req", int'(mem_req), 0);
      @(posedge clk); #1;
      check("first_fetch_mem_req", int'(mem_req), 1);
      check("first_fetch_iord", int'(iord), 0);

      // ADD, memory ready on first request
      r0 = obs_retire;
      add_instr(7'b0110011, 0, 0, 0);
      check("add_sched_len", sched.size(), 4);
      run_phase();
      $display("ADD done");
      check("add_retire_count", obs_retire - r0, 1);
      check("add_retire_cycle", obs_retire_cyc, 4);
      check("add_regwe_cycle", obs_regwe_cyc, 4);

      // LW, fetch delay 3 (ready in the watchdog limit cycle), data delay 2
      r0 = obs_retire; q0 = obs_memreq;
      add_instr(7'b0000011, 3, 2, 0);
      run_phase();
      $display("LW done");
      check("lw_retire_count", obs_retire - r0, 1);
      check("lw_retire_cycle", obs_retire_cyc, 10);
      check("lw_mem_req_cycles", obs_memreq - q0, 7);

      // BEQ not taken then taken
      p0 = obs_pcwe; r0 = obs_retire;
      add_instr(7'b1100011, 1, 0, 0);
      run_phase();
      check("beq_nt_pc_we_count", obs_pcwe - p0, 1);
      p0 = obs_pcwe;
      add_instr(7'b1100011, 0, 0, 1);
      run_phase();
      $display("BEQ pair done");
      check("beq_t_pc_we_count", obs_pcwe - p0, 2);
      check("beq_retire_count", obs_retire - r0, 2);

      // ADDI, LUI, SW, JAL, JALR
      r0 = obs_retire;
      add_instr(7'b0010011, 0, 0, 0);
      add_instr(7'b0110111, 2, 0, 0);
      add_instr(7'b0100011, 0, 1, 0);
      add_instr(7'b1101111, 0, 0, 0);
      add_instr(7'b1100111, 1, 0, 0);
      run_phase();
      $display("ADDI/LUI/SW/JAL/JALR done");
      check("mix_retire_count", obs_retire - r0, 5);

      // Illegal opcode traps after DECODE, stays quiet 20 cycles
      q0 = obs_memreq;
      add_instr(7'h7F, 0, 0, 0);
      add_trap(20);
      run_phase();
      $display("illegal opcode done");
      check("illegal_flag", int'(illegal_instr), 1);
      check("illegal_busy", int'(busy), 0);
      check("illegal_mem_req_cycles", obs_memreq - q0, 1);

      // Reset clears sticky flags
      @(negedge clk) reset = 0;
      #1 check("reset2_outputs_zero", int'(act), 0);
      m_ill = 0; m_berr = 0; m_trap = 0;
      @(negedge clk) reset = 1;
      @(posedge clk); #1;

      // Reset in the middle of a waiting fetch drops mem_req at once
      begin
         bit ok;
         mem_wait(2, 7'h33, 1'b0, 1'b0, ok);
      end
      run_phase();
      mem_ready = 0;
      #2 reset = 0;
      #1 check("mid_access_reset_mem_req", int'(mem_req), 0);
      $display("mid-access reset done");
      @(negedge clk) reset = 1;
      @(posedge clk); #1;

      // Watchdog: fetch never answered
      q0 = obs_memreq;
      add_instr(7'h33, 100, 0, 0);
      add_trap(5);
      run_phase();
      $display("watchdog expiry done");
      check("wdog_bus_err", int'(bus_err), 1);
      check("wdog_illegal_clear", int'(illegal_instr), 0);
      check("wdog_mem_req_cycles", obs_memreq - q0, TMO);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
